fetch_prefetch_queue: RTL and testbench

Parametrised instruction fetch stage with an N-deep prefetch queue and a decoupled valid/ready instruction-memory interface.
- Supports multiple outstanding IMEM requests, in-order responses with any latency of 1 or more cycles, and redirect (branch/jump) handling.
- Responses still in flight at a redirect are squashed.
- Sits between IMEM and the decode stage; feeds the IF/ID pipeline registers and takes stall from the hazard unit and redirects from execute.

---
 rtl/fetch_prefetch_queue.sv | 126 ++++++++++++
 tb/tb_fetch_prefetch_queue.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_prefetch_queue.sv
// Instruction fetch stage with an N-deep prefetch queue and in-order IMEM.
// Optional same-cycle response bypass: define FETCH_QUEUE_BYPASS_EN.
module fetch_prefetch_queue #(
    parameter int              XLEN       = 32,
    parameter int              DEPTH      = 4,
    parameter logic [XLEN-1:0] RESET_ADDR = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            IMEM_req_valid_o,
    input  logic            IMEM_req_ready_i,
    output logic [XLEN-1:0] IMEM_addr_o,
    input  logic            IMEM_rsp_valid_i,
    input  logic [XLEN-1:0] IMEM_rsp_data_i,
    input  logic            PIP_pc_load_i,
    input  logic [XLEN-1:0] PIP_target_address_i,
    input  logic            stall_i,
    output logic            PIP_valid_o,
    output logic [XLEN-1:0] PIP_instruction_o,
    output logic [XLEN-1:0] PIP_pc_o
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]   count_q, count_d;
    logic [CW-1:0]   inflight_q, inflight_d;
    logic [CW-1:0]   discard_q, discard_d;
    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [XLEN-1:0] mem_pc_q  [DEPTH];
    logic [XLEN-1:0] mem_ins_q [DEPTH];

    logic          issue;
    logic          rsp_keep;
    logic          bypass;
    logic          head_valid;
    logic          deq;
    logic          wr_en;
    logic [CW:0]   used;

    // Credit check: queued plus outstanding never exceeds DEPTH
    always_comb begin
        used             = {1'b0, count_q} + {1'b0, inflight_q};
        IMEM_req_valid_o = !reset && !PIP_pc_load_i
                           && (used < (CW+1)'(DEPTH));
        IMEM_addr_o      = fetch_pc_q;
        issue            = IMEM_req_valid_o && IMEM_req_ready_i;
    end

    // Head presentation, optionally fed straight from the response
    always_comb begin
        rsp_keep   = IMEM_rsp_valid_i && (discard_q == '0);
        head_valid = (count_q != '0);
`ifdef FETCH_QUEUE_BYPASS_EN
        bypass     = rsp_keep && !head_valid && !PIP_pc_load_i && !reset;
`else
        bypass     = 1'b0;
`endif
        PIP_valid_o       = head_valid || bypass;
        PIP_pc_o          = '0;
        PIP_instruction_o = '0;
        if (head_valid) begin
            PIP_pc_o          = mem_pc_q[head_q];
            PIP_instruction_o = mem_ins_q[head_q];
        end else if (bypass) begin
            PIP_pc_o          = rsp_pc_q;
            PIP_instruction_o = IMEM_rsp_data_i;
        end
        deq   = head_valid && !stall_i;
        wr_en = rsp_keep && !(bypass && !stall_i) && !PIP_pc_load_i;
    end

    // Next-state for PCs, counters and pointers; redirect overrides all
    always_comb begin
        fetch_pc_d = fetch_pc_q + (issue ? XLEN'(4) : XLEN'(0));
        rsp_pc_d   = rsp_pc_q + (rsp_keep ? XLEN'(4) : XLEN'(0));
        inflight_d = inflight_q + CW'(issue) - CW'(IMEM_rsp_valid_i);
        discard_d  = discard_q
                     - CW'(IMEM_rsp_valid_i && (discard_q != '0));
        count_d    = count_q + CW'(wr_en) - CW'(deq);
        head_d     = head_q + PW'(deq);
        tail_d     = tail_q + PW'(wr_en);
        if (PIP_pc_load_i) begin
            fetch_pc_d = PIP_target_address_i;
            rsp_pc_d   = PIP_target_address_i;
            count_d    = '0;
            head_d     = '0;
            tail_d     = '0;
            inflight_d = inflight_q - CW'(IMEM_rsp_valid_i);
            discard_d  = inflight_q - CW'(IMEM_rsp_valid_i);
        end
    end

    // Control state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q <= RESET_ADDR;
            rsp_pc_q   <= RESET_ADDR;
            count_q    <= '0;
            inflight_q <= '0;
            discard_q  <= '0;
            head_q     <= '0;
            tail_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            discard_q  <= discard_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
        end
    end

    // Queue storage, written at the tail with the response PC
    always_ff @(posedge clk) begin
        if (!reset && wr_en) begin
            mem_pc_q[tail_q]  <= rsp_pc_q;
            mem_ins_q[tail_q] <= IMEM_rsp_data_i;
        end
    end

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Directed bench for fetch_prefetch_queue with an in-order IMEM model.
// Each scenario task checks its own results inline.
module tb_fetch_prefetch_queue;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] addr;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        pc_load;
    logic [31:0] target;
    logic        stall;
    logic        pip_valid;
    logic [31:0] pip_ins;
    logic [31:0] pip_pc;

    fetch_prefetch_queue dut (
        .clk                  (clk),
        .reset                (reset),
        .IMEM_req_valid_o     (req_valid),
        .IMEM_req_ready_i     (req_ready),
        .IMEM_addr_o          (addr),
        .IMEM_rsp_valid_i     (rsp_valid),
        .IMEM_rsp_data_i      (rsp_data),
        .PIP_pc_load_i        (pc_load),
        .PIP_target_address_i (target),
        .stall_i              (stall),
        .PIP_valid_o          (pip_valid),
        .PIP_instruction_o    (pip_ins),
        .PIP_pc_o             (pip_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int failures;
    int cyc;
    int lat;

    logic        o_rv;
    logic [31:0] o_addr;
    logic        o_pv;
    logic [31:0] o_pc;
    logic [31:0] o_ins;

    logic [31:0] mq_addr[$];
    int          mq_due[$];
    logic [31:0] acc_addr[$];
    logic [31:0] cons_pc[$];
    logic [31:0] cons_ins[$];
    int          cons_cyc[$];

    function automatic logic [31:0] fdata(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    // One clock cycle: drive response, observe, then advance
    task automatic step();
        if (!reset && mq_addr.size() > 0 && mq_due[0] <= cyc) begin
            rsp_valid = 1'b1;
            rsp_data  = fdata(mq_addr[0]);
            void'(mq_addr.pop_front());
            void'(mq_due.pop_front());
        end else begin
            rsp_valid = 1'b0;
            rsp_data  = '0;
        end
        #1;
        o_rv   = req_valid;
        o_addr = addr;
        o_pv   = pip_valid;
        o_pc   = pip_pc;
        o_ins  = pip_ins;
        if (o_rv && req_ready) begin
            acc_addr.push_back(o_addr);
            mq_addr.push_back(o_addr);
            mq_due.push_back(cyc + lat);
        end
        if (o_pv && !stall) begin
            cons_pc.push_back(o_pc);
            cons_ins.push_back(o_ins);
            cons_cyc.push_back(cyc);
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        pc_load   = 1'b0;
        target    = '0;
        stall     = 1'b0;
        req_ready = 1'b1;
        mq_addr.delete();
        mq_due.delete();
        step();
        step();
        reset = 1'b0;
        cyc   = 0;
        acc_addr.delete();
        cons_pc.delete();
        cons_ins.delete();
        cons_cyc.delete();
    endtask

    task automatic wait_cons(input int n);
        for (int i = 0; i < 60 && cons_pc.size() < n; i++) step();
        checks++;
        if (cons_pc.size() < n) begin
            failures++;
            $display("FAIL cons_timeout got=%0d want=%0d",
                     cons_pc.size(), n);
        end
    endtask

    task automatic test_reset();
        lat = 1;
        reset = 1'b1;
        step();
        do_reset();
        checks++;
        if (o_rv !== 1'b0) begin
            failures++;
            $display("FAIL rst_req_valid got=%b want=0", o_rv);
        end
        checks++;
        if (o_pv !== 1'b0) begin
            failures++;
            $display("FAIL rst_pip_valid got=%b want=0", o_pv);
        end
        checks++;
        if (o_pc !== 32'h0 || o_ins !== 32'h0) begin
            failures++;
            $display("FAIL rst_pip_zero pc=%h ins=%h want=0", o_pc, o_ins);
        end
        req_ready = 1'b0;
        step();
        checks++;
        if (o_rv !== 1'b1 || o_addr !== 32'h0) begin
            failures++;
            $display("FAIL rst_first_req v=%b a=%h want 1/0", o_rv, o_addr);
        end
    endtask

    task automatic test_stream();
        lat = 1;
        do_reset();
        wait_cons(8);
        if (cons_pc.size() >= 8) begin
            checks++;
`ifdef FETCH_QUEUE_BYPASS_EN
            if (cons_cyc[0] != 1) begin
`else
            if (cons_cyc[0] != 2) begin
`endif
                failures++;
                $display("FAIL stream_fill got=%0d", cons_cyc[0]);
            end
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (cons_pc[i] !== 32'(4 * i)
                    || cons_ins[i] !== fdata(32'(4 * i))
                    || cons_cyc[i] != cons_cyc[0] + i) begin
                    failures++;
                    $display("FAIL stream_%0d pc=%h ins=%h c=%0d",
                             i, cons_pc[i], cons_ins[i], cons_cyc[i]);
                end
            end
        end
        checks++;
        if (acc_addr[3] !== 32'hC) begin
            failures++;
            $display("FAIL stream_req3 got=%h want=c", acc_addr[3]);
        end
    endtask

    task automatic test_stall_full();
        lat = 1;
        do_reset();
        stall = 1'b1;
        for (int i = 0; i < 8; i++) step();
        checks++;
        if (acc_addr.size() != 4) begin
            failures++;
            $display("FAIL stall_reqs got=%0d want=4", acc_addr.size());
        end
        checks++;
        if (o_rv !== 1'b0) begin
            failures++;
            $display("FAIL stall_req_valid got=%b want=0", o_rv);
        end
        checks++;
        if (o_pv !== 1'b1 || o_pc !== 32'h0) begin
            failures++;
            $display("FAIL stall_head v=%b pc=%h want 1/0", o_pv, o_pc);
        end
        stall = 1'b0;
        wait_cons(5);
        for (int i = 0; i < 5 && i < cons_pc.size(); i++) begin
            checks++;
            if (cons_pc[i] !== 32'(4 * i)
                || cons_ins[i] !== fdata(32'(4 * i))) begin
                failures++;
                $display("FAIL stall_drain_%0d pc=%h ins=%h",
                         i, cons_pc[i], cons_ins[i]);
            end
        end
    endtask

    task automatic test_redirect_inflight();
        lat = 3;
        do_reset();
        step();
        step();
        req_ready = 1'b0;
        pc_load   = 1'b1;
        target    = 32'h100;
        step();
        pc_load   = 1'b0;
        req_ready = 1'b1;
        wait_cons(3);
        for (int i = 0; i < 3 && i < cons_pc.size(); i++) begin
            checks++;
            if (cons_pc[i] !== 32'h100 + 32'(4 * i)
                || cons_ins[i] !== fdata(32'h100 + 32'(4 * i))) begin
                failures++;
                $display("FAIL redir_%0d pc=%h ins=%h",
                         i, cons_pc[i], cons_ins[i]);
            end
        end
    endtask

    task automatic test_redirect_with_rsp();
        lat = 2;
        do_reset();
        stall = 1'b1;
        step();
        step();
        step();
        pc_load = 1'b1;
        target  = 32'h200;
        step();
        checks++;
        if (o_rv !== 1'b0) begin
            failures++;
            $display("FAIL redir_rsp_req got=%b want=0", o_rv);
        end
        pc_load = 1'b0;
        stall   = 1'b0;
        step();
        checks++;
        if (o_pv !== 1'b0) begin
            failures++;
            $display("FAIL redir_rsp_flush got=%b want=0", o_pv);
        end
        wait_cons(2);
        for (int i = 0; i < 2 && i < cons_pc.size(); i++) begin
            checks++;
            if (cons_pc[i] !== 32'h200 + 32'(4 * i)
                || cons_ins[i] !== fdata(32'h200 + 32'(4 * i))) begin
                failures++;
                $display("FAIL redir_rsp_%0d pc=%h ins=%h",
                         i, cons_pc[i], cons_ins[i]);
            end
        end
    endtask

    task automatic test_ready_low();
        lat = 1;
        do_reset();
        step();
        step();
        req_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (o_rv !== 1'b1 || o_addr !== 32'h8) begin
                failures++;
                $display("FAIL hold_%0d v=%b a=%h want 1/8", i, o_rv, o_addr);
            end
        end
        req_ready = 1'b1;
        wait_cons(5);
        for (int i = 0; i < 5 && i < cons_pc.size(); i++) begin
            checks++;
            if (cons_pc[i] !== 32'(4 * i)
                || cons_ins[i] !== fdata(32'(4 * i))) begin
                failures++;
                $display("FAIL hold_seq_%0d pc=%h ins=%h",
                         i, cons_pc[i], cons_ins[i]);
            end
        end
    endtask

`ifdef FETCH_QUEUE_BYPASS_EN
    task automatic test_bypass();
        lat = 1;
        do_reset();
        pc_load = 1'b1;
        target  = 32'h40;
        step();
        pc_load = 1'b0;
        step();
        req_ready = 1'b0;
        step();
        checks++;
        if (o_pv !== 1'b1 || o_pc !== 32'h40 || o_ins !== fdata(32'h40)) begin
            failures++;
            $display("FAIL bypass v=%b pc=%h ins=%h", o_pv, o_pc, o_ins);
        end
        step();
        checks++;
        if (o_pv !== 1'b0) begin
            failures++;
            $display("FAIL bypass_empty got=%b want=0", o_pv);
        end
    endtask
`endif

    initial begin
        checks    = 0;
        failures  = 0;
        cyc       = 0;
        lat       = 1;
        reset     = 1'b1;
        req_ready = 1'b1;
        rsp_valid = 1'b0;
        rsp_data  = '0;
        pc_load   = 1'b0;
        target    = '0;
        stall     = 1'b0;
        @(negedge clk);
        test_reset();
        test_stream();
        test_stall_full();
        test_redirect_inflight();
        test_redirect_with_rsp();
        test_ready_low();
`ifdef FETCH_QUEUE_BYPASS_EN
        test_bypass();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
